// File: rtl/k005297_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : k005297_pkg
//  Description : Shared constants, search-state encoding and the next-page
//                predictor for the K005297 absolute page decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package k005297_pkg;

   localparam int PG_MOD     = 1531;   // page modulus, legal pages 0..PG_MOD-1
   localparam int PG_STEP    = 522;    // page advance per rotation
   localparam int SLOT_BIT0  = 0;      // ROT20 slot carrying page bit 0
   localparam int SLOT_LATCH = 12;     // ROT20 slot where the word is latched

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FOUND = 2'd2,
      ST_TMO   = 2'd3
   } srch_st_t;

   // Next expected page: p + step, folded once by the modulus.
   // Legal inputs stay below 2053, so 12 bits hold the sum.
   function automatic logic [11:0] pg_next(input logic [11:0] p,
                                           input logic [11:0] step,
                                           input logic [11:0] pmod);
      logic [11:0] sum;
      sum = p + step;
      return (sum >= pmod) ? (sum - pmod) : sum;
   endfunction

endpackage
`default_nettype wire

// File: rtl/k005297_abspgdec_deser.sv
`default_nettype none
// ============================================================================
//  Module      : k005297_abspgdec_deser
//  Description : Serial-to-parallel page deserializer. Captures bit k in ROT20
//                slot k (0..11), latches the word in slot 12 and qualifies it
//                with wordok so a word started before reset is never reported.
//  Revision    : 1.0  initial release
// ============================================================================
module k005297_abspgdec_deser (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [12:0] slot_n,
   input  logic        ser_bit,
   output logic [11:0] shreg,
   output logic        word_done,
   output logic [11:0] word,
   output logic        word_valid
);
   import k005297_pkg::*;

   logic wordok;

   // A word completes at the slot 12 enable, but only once slot 0 was seen.
   assign word_done = en & ~slot_n[SLOT_LATCH] & wordok;

   // Shift-in, word latch and wordok tracking; all state holds while disabled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg      <= '0;
         wordok     <= 1'b0;
         word       <= '0;
         word_valid <= 1'b0;
      end else if (en) begin
         word_valid <= 1'b0;
         for (int k = 0; k < 12; k++) begin
            if (!slot_n[k]) shreg[k] <= ser_bit;
         end
         if (!slot_n[SLOT_BIT0]) wordok <= 1'b1;
         if (word_done) begin
            word       <= shreg;
            word_valid <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/k005297_abspgdec.sv
`default_nettype none
// ============================================================================
//  Module      : k005297_abspgdec
//  Description : Absolute page decoder and page search unit. Assembles the
//                serial page stream, flags out-of-range words and runs a
//                host-armed search for a target page with a word timeout.
//                Optional feature macro: K005297_ABSPGDEC_SEQCHK_EN enables
//                the sticky page-sequence checker (o_PG_SEQ_ERR).
//  Revision    : 1.0  initial release
// ============================================================================
module k005297_abspgdec #(
   parameter int PG_MOD    = k005297_pkg::PG_MOD,
   parameter int PG_STEP   = k005297_pkg::PG_STEP,
   parameter int TMO_WORDS = 1531
) (
   input  logic        i_MCLK,
   input  logic        i_RST_n,
   input  logic        i_CLK2M_PCEN_n,
   input  logic [19:0] i_ROT20_n,
   input  logic        i_ABSPGCNTR_LSB,
   input  logic        i_SEARCH_START,
   input  logic        i_SEARCH_STOP,
   input  logic [11:0] i_TARGET_PG,
   output logic [11:0] o_ABSPG,
   output logic        o_ABSPG_VALID,
   output logic        o_PG_RANGE_ERR,
   output logic        o_PG_SEQ_ERR,
   output logic        o_SEARCH_BUSY,
   output logic        o_PG_FOUND,
   output logic        o_SEARCH_TMO,
   output logic [10:0] o_WORD_CNT
);
   import k005297_pkg::*;

   localparam logic [11:0] MOD12  = 12'(PG_MOD);
   localparam logic [10:0] TMO_LIM = 11'(TMO_WORDS);

   logic        en;
   logic        start_evt;
   logic        stop_evt;
   logic        word_done;
   logic [11:0] cur_word;
   logic        unused_slots;

   srch_st_t    state,    state_nx;
   logic [11:0] target,   target_nx;
   logic [10:0] cnt_nx;
   logic        found_nx, tmo_nx;

   assign en        = ~i_CLK2M_PCEN_n;
   assign stop_evt  = en & i_SEARCH_STOP;
   // A start re-arms only from a non-armed state; stop takes priority.
   assign start_evt = en & i_SEARCH_START & ~i_SEARCH_STOP & (state != ST_ARMED);
   // Slots 13..19 carry nothing for this block.
   assign unused_slots = &i_ROT20_n[19:13];

   k005297_abspgdec_deser u_deser (
      .clk        (i_MCLK),
      .rst_n      (i_RST_n),
      .en         (en),
      .slot_n     (i_ROT20_n[12:0]),
      .ser_bit    (i_ABSPGCNTR_LSB),
      .shreg      (cur_word),
      .word_done  (word_done),
      .word       (o_ABSPG),
      .word_valid (o_ABSPG_VALID)
   );

   // Range flag follows the latched word.
   always_ff @(posedge i_MCLK) begin
      if (!i_RST_n)       o_PG_RANGE_ERR <= 1'b0;
      else if (word_done) o_PG_RANGE_ERR <= (cur_word >= MOD12);
   end

   // Search FSM and result registers.
   always_ff @(posedge i_MCLK) begin
      if (!i_RST_n) begin
         state        <= ST_IDLE;
         target       <= '0;
         o_WORD_CNT   <= '0;
         o_PG_FOUND   <= 1'b0;
         o_SEARCH_TMO <= 1'b0;
      end else if (en) begin
         state        <= state_nx;
         target       <= target_nx;
         o_WORD_CNT   <= cnt_nx;
         o_PG_FOUND   <= found_nx;
         o_SEARCH_TMO <= tmo_nx;
      end
   end

   // Search next-state: a match beats the timeout on the same word.
   always_comb begin
      state_nx = state;
      target_nx = target;
      cnt_nx   = o_WORD_CNT;
      found_nx = o_PG_FOUND;
      tmo_nx   = o_SEARCH_TMO;
      if (stop_evt) begin
         state_nx = ST_IDLE;
      end else if (start_evt) begin
         state_nx  = ST_ARMED;
         target_nx = i_TARGET_PG;
         cnt_nx    = '0;
         found_nx  = 1'b0;
         tmo_nx    = 1'b0;
      end else if (state == ST_ARMED && word_done) begin
         if (cur_word == target) begin
            state_nx = ST_FOUND;
            found_nx = 1'b1;
         end else begin
            cnt_nx = o_WORD_CNT + 11'd1;
            if (cnt_nx == TMO_LIM) begin
               state_nx = ST_TMO;
               tmo_nx   = 1'b1;
            end
         end
      end
   end

   assign o_SEARCH_BUSY = (state == ST_ARMED);

`ifdef K005297_ABSPGDEC_SEQCHK_EN
   localparam logic [11:0] STEP12 = 12'(PG_STEP);

   logic [11:0] exp_pg;
   logic        have_prev;

   // Sticky sequence checker: compares each word with the prediction from
   // the previous one; out-of-range words always count as a break.
   always_ff @(posedge i_MCLK) begin
      if (!i_RST_n) begin
         exp_pg       <= '0;
         have_prev    <= 1'b0;
         o_PG_SEQ_ERR <= 1'b0;
      end else if (en) begin
         if (start_evt) o_PG_SEQ_ERR <= 1'b0;
         if (word_done) begin
            exp_pg    <= pg_next(cur_word, STEP12, MOD12);
            have_prev <= 1'b1;
            if ((cur_word >= MOD12) || (have_prev && (cur_word != exp_pg)))
               o_PG_SEQ_ERR <= 1'b1;
         end
      end
   end
`else
   logic [11:0] unused_step;
   assign unused_step  = 12'(PG_STEP);
   assign o_PG_SEQ_ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_k005297_abspgdec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_k005297_abspgdec
//  Description : Scoreboard bench for the absolute page decoder: the driver
//                queues expected words, a monitor pops them on each VALID.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_k005297_abspgdec;

`ifdef K005297_ABSPGDEC_SEQCHK_EN
   localparam bit SEQ_ON = 1'b1;
`else
   localparam bit SEQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, pcen_n, ser, start, stop;
   logic [19:0] rot_n;
   logic [11:0] target;
   logic [11:0] abspg;
   logic        valid, rng_err, seq_err, busy, found, tmo;
   logic [10:0] wcnt;

   always #5 clk = ~clk;

   k005297_abspgdec dut (
      .i_MCLK          (clk),
      .i_RST_n         (rst_n),
      .i_CLK2M_PCEN_n  (pcen_n),
      .i_ROT20_n       (rot_n),
      .i_ABSPGCNTR_LSB (ser),
      .i_SEARCH_START  (start),
      .i_SEARCH_STOP   (stop),
      .i_TARGET_PG     (target),
      .o_ABSPG         (abspg),
      .o_ABSPG_VALID   (valid),
      .o_PG_RANGE_ERR  (rng_err),
      .o_PG_SEQ_ERR    (seq_err),
      .o_SEARCH_BUSY   (busy),
      .o_PG_FOUND      (found),
      .o_SEARCH_TMO    (tmo),
      .o_WORD_CNT      (wcnt)
   );

   typedef struct packed {
      logic [11:0] pg;
      logic        rng;
      logic        seq;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   logic prev_v = 1'b0;

   // reference model state for the sequence flag
   bit   m_have = 1'b0;
   int   m_prev = 0;
   bit   m_seq  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: one pop per VALID pulse (rising edge, since disabled cycles stretch it)
   always @(negedge clk) begin
      if (valid === 1'b1 && prev_v !== 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got word %0d expected no VALID", abspg);
         end else begin
            mon_e = sb.pop_front();
            check("abspg", 32'(abspg), 32'(mon_e.pg));
            check("range_err", 32'(rng_err), 32'(mon_e.rng));
            check("seq_err", 32'(seq_err), 32'(mon_e.seq));
         end
      end
      prev_v = valid;
   end

   task automatic push_word(input logic [11:0] w);
      exp_t e;
      bit   rng;
      rng = (w >= 12'd1531);
      if (SEQ_ON) begin
         if (rng || (m_have && (int'(w) != (m_prev + 522) % 1531))) m_seq = 1'b1;
      end
      m_have = 1'b1;
      m_prev = int'(w);
      e.pg  = w;
      e.rng = rng;
      e.seq = m_seq;
      sb.push_back(e);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One 20-slot word; optional start pulse in slot start_at, optional
   // disabled cycles carrying junk that must be ignored.
   task automatic send_word(input logic [11:0] w, input bit expv, input int start_at, input bit hold);
      for (int s = 0; s < 20; s++) begin
         if (hold && (s == 4 || s == 13)) begin
            pcen_n = 1'b1;
            rot_n  = ~20'd1;
            ser    = 1'b1;
            start  = 1'b0;
            step();
         end
         pcen_n = 1'b0;
         rot_n  = ~(20'd1 << s);
         ser    = (s < 12) ? w[s] : 1'b0;
         start  = (s == start_at);
         if (s == start_at) m_seq = 1'b0;
         if (s == 12 && expv) push_word(w);
         step();
      end
      start = 1'b0;
   endtask

   task automatic do_reset;
      rst_n  = 1'b0;
      pcen_n = 1'b0;
      rot_n  = ~(20'd1 << 19);
      ser    = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      repeat (3) step();
      rst_n  = 1'b1;
      m_have = 1'b0;
      m_seq  = 1'b0;
   endtask

   initial begin
      int p;
      target = 12'd0;
      do_reset();
      rst_n = 1'b0;
      // reset state
      check("rst_abspg", 32'(abspg), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_range", 32'(rng_err), 0);
      check("rst_seq", 32'(seq_err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_found", 32'(found), 0);
      check("rst_tmo", 32'(tmo), 0);
      check("rst_wcnt", 32'(wcnt), 0);
      rst_n = 1'b1;

      // basic word, with junk on disabled cycles
      send_word(12'd522, 1'b1, -1, 1'b1);
      check("valid_single_pulse", 32'(valid), 0);
      send_word(12'd1044, 1'b1, -1, 1'b0);

      // legal wrap 1009 -> 0
      do_reset();
      send_word(12'd1009, 1'b1, -1, 1'b0);
      send_word(12'd0, 1'b1, -1, 1'b0);

      // 1530 -> 522 breaks sequence (521 expected)
      do_reset();
      send_word(12'd1530, 1'b1, -1, 1'b0);
      send_word(12'd522, 1'b1, -1, 1'b0);

      // out-of-range word, then a legal one
      do_reset();
      send_word(12'd1600, 1'b1, -1, 1'b0);
      send_word(12'd0, 1'b1, -1, 1'b0);

      // search hit on the third word; start mid-word
      do_reset();
      target = 12'd1044;
      send_word(12'd0, 1'b1, 5, 1'b0);
      check("srch_busy_armed", 32'(busy), 1);
      check("srch_cnt_1", 32'(wcnt), 1);
      send_word(12'd522, 1'b1, -1, 1'b0);
      send_word(12'd1044, 1'b1, -1, 1'b0);
      check("srch_found", 32'(found), 1);
      check("srch_cnt_2", 32'(wcnt), 2);
      check("srch_busy_done", 32'(busy), 0);
      check("srch_tmo_clear", 32'(tmo), 0);
      send_word(12'd35, 1'b1, -1, 1'b0);
      check("srch_found_hold", 32'(found), 1);
      check("srch_cnt_hold", 32'(wcnt), 2);

      // start and stop together: stop wins, no re-arm
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("startstop_busy", 32'(busy), 0);
      check("startstop_found", 32'(found), 1);

      // timeout: target never appears in a legal stream
      do_reset();
      target = 12'd1600;
      p = 0;
      for (int i = 0; i < 1531; i++) begin
         send_word(12'(p), 1'b1, (i == 0) ? 5 : -1, 1'b0);
         p = (p + 522) % 1531;
         if (i == 1529) begin
            check("tmo_busy_before", 32'(busy), 1);
            check("tmo_cnt_before", 32'(wcnt), 1530);
            check("tmo_flag_before", 32'(tmo), 0);
         end
      end
      check("tmo_flag", 32'(tmo), 1);
      check("tmo_cnt", 32'(wcnt), 1531);
      check("tmo_found", 32'(found), 0);
      check("tmo_busy", 32'(busy), 0);

      // reset asserted in slots 6..8 of a word: that word never completes
      for (int s = 0; s < 20; s++) begin
         pcen_n = 1'b0;
         rot_n  = ~(20'd1 << s);
         ser    = (s < 12) ? 1'b1 : 1'b0;
         rst_n  = !(s >= 6 && s <= 8);
         if (s == 6) begin
            m_have = 1'b0;
            m_seq  = 1'b0;
         end
         step();
      end
      rst_n = 1'b1;
      check("midreset_busy", 32'(busy), 0);
      check("midreset_tmo", 32'(tmo), 0);
      send_word(12'd777, 1'b1, -1, 1'b0);

      repeat (3) step();
      check("scoreboard_empty", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
